gf_div: RTL
===========

Name: gf_div

Overview:
- Sequential GF(2) polynomial (carry-less) divider: inverse of the combinational carry-less multiplier.
- Takes a 2*DATA_WIDTH-bit dividend polynomial and a DATA_WIDTH-bit divisor polynomial.
- Produces quotient and remainder by bit-serial long division, one dividend bit per clock.
- Sits downstream of the multiplier for modular reduction and quotient recovery. Valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 32, divisor/remainder width; dividend and quotient are 2*DATA_WIDTH.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  dividend/divisor valid
- in_ready  output  1  block can accept an operand pair
- dividend  input  2*DATA_WIDTH  dividend polynomial, bit i = coefficient of x^i
- divisor  input  DATA_WIDTH  divisor polynomial, same bit order
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  2*DATA_WIDTH  quotient polynomial
- remainder  output  DATA_WIDTH  remainder polynomial, degree < deg(divisor)

Behaviour:
- Single clock domain (clk); rst synchronous, active-high.
- Reset values: in_ready=1, out_valid=0, quotient=0, remainder=0. State IDLE; counter, shift registers and deg all 0.
- A reset asserted mid-RUN or in DONE aborts the operation: the result is discarded and IDLE is entered next cycle.
- FSM has three states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid&&in_ready: latch dividend into the shift register D, latch divisor into V.
  - Latch deg = index of highest set bit of divisor (priority encode). Clear R and Q, set cnt=2*DATA_WIDTH.
  - Divisor nonzero -> RUN. Divisor zero -> DONE with Q=0, R=0.
- RUN: in_ready=0. Each cycle:
  - t = {R, D[MSB]} (DATA_WIDTH+1 bits), then qb = t[deg].
  - If qb is set, t ^= V (zero-extended).
  - R <= t[DATA_WIDTH-1:0]; Q <= {Q[2*DATA_WIDTH-2:0], qb}; D <= D<<1; cnt <= cnt-1.
  - Leaves RUN after 2*DATA_WIDTH iterations -> DONE.
- DONE: out_valid=1, quotient=Q, remainder=R.
  - Outputs are held stable while out_ready=0 (backpressure of unbounded length).
  - On out_ready=1 -> IDLE next cycle. No new operand is accepted in the same cycle.
- Latency: accept edge to out_valid = 2*DATA_WIDTH+1 cycles for a nonzero divisor, 1 cycle for a zero divisor. Throughput is one operation per 2*DATA_WIDTH+2 cycles minimum.
- Boundary cases:
  - divisor=1 (deg 0): quotient=dividend, remainder=0.
  - deg(dividend) < deg(divisor): quotient=0, remainder=dividend low bits.
  - dividend=0: quotient=0, remainder=0.
  - Full-width divisor (bit DATA_WIDTH-1 set) is legal; R never exceeds deg-1 bits set.
- in_valid while busy is ignored. The source must hold it until in_ready.

Optional Feature:
- Macro GF_DIV_ZERO_ERR_EN.
- Defined: adds output port div_err (1 bit, reset 0). div_err=1 together with out_valid for a zero divisor, 0 otherwise; it is held with the outputs under backpressure.
- Undefined: no port. A zero divisor silently returns quotient=0, remainder=0 with 1-cycle latency.

Decomposition:
- Shared package gf_pkg holds:
  - FSM state typedef (IDLE/RUN/DONE).
  - Localparam helpers: PROD_WIDTH = 2*DATA_WIDTH, counter width = $clog2(2*DATA_WIDTH+1).
- One natural sub-module: gf_deg (combinational priority encoder, DATA_WIDTH in, $clog2(DATA_WIDTH) out plus zero flag). It is reusable by future reduction/inversion blocks.

Test Plan:
- DATA_WIDTH=8, dividend=16'h0011, divisor=8'h03 -> quotient=16'h000F, remainder=8'h00, out_valid exactly 17 cycles after accept.
- dividend=16'h0005, divisor=8'h07 -> quotient=16'h0001, remainder=8'h02. Then dividend=16'h0003, divisor=8'h08 -> quotient=0, remainder=8'h03.
- divisor=8'h00, any dividend -> out_valid 1 cycle after accept, quotient=0, remainder=0. With GF_DIV_ZERO_ERR_EN, div_err=1 for that result and 0 for the next nonzero-divisor op.
- divisor=8'h01, dividend=16'hBEEF -> quotient=16'hBEEF, remainder=0. out_ready held low 10 cycles -> outputs stable, in_ready=0 throughout.
- Assert rst mid-RUN (cycle 5) -> next cycle in_ready=1, out_valid=0, no result emitted. A following op returns a correct result.
- Random a, b≠0, r with deg r<deg b: dividend = clmul(a,b)^r -> quotient=a, remainder=r (1000 iterations, golden via multiplier model).

Source files
------------

// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared types and width helpers for the GF(2) polynomial arithmetic blocks
package gf_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gf_state_e;

    localparam int DATA_WIDTH_DEFAULT = 32;

    // Width of a product / dividend polynomial for a given operand width
    function automatic int prod_width(input int data_width);
        return 2 * data_width;
    endfunction

    // Counter width able to hold the full iteration count 2*DATA_WIDTH
    function automatic int cnt_width(input int data_width);
        return $clog2(2 * data_width + 1);
    endfunction

endpackage

// File: rtl/gf_div_if.sv
// rtl/gf_div_if.sv - operand/result handshake bundle for gf_div (div_err present under GF_DIV_ZERO_ERR_EN)
interface gf_div_if
    import gf_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);
    localparam int PW = prod_width(DATA_WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [PW-1:0]         dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [PW-1:0]         quotient;
    logic [DATA_WIDTH-1:0] remainder;
`ifdef GF_DIV_ZERO_ERR_EN
    logic                  div_err;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_err
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_err
    );
`else
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder
    );
`endif

endinterface

// File: rtl/gf_deg.sv
// rtl/gf_deg.sv - polynomial degree finder (priority encoder on the highest set coefficient)
module gf_deg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]         poly_i,
    output logic [$clog2(DATA_WIDTH)-1:0] deg_o,
    output logic                          zero_o
);
    localparam int DEG_W = $clog2(DATA_WIDTH);

    // Scan upward so the highest set coefficient wins; zero polynomial reports degree 0 with zero_o set
    always_comb begin
        deg_o  = '0;
        zero_o = 1'b1;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (poly_i[i]) begin
                deg_o  = DEG_W'(i);
                zero_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/gf_div.sv
// rtl/gf_div.sv - bit-serial GF(2) polynomial divider, one dividend bit per clock (optional GF_DIV_ZERO_ERR_EN adds div_err)
module gf_div
    import gf_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    gf_div_if.slave  bus
);
    localparam int PW = prod_width(DATA_WIDTH);
    localparam int CW = cnt_width(DATA_WIDTH);
    localparam int DW = $clog2(DATA_WIDTH);
    localparam int TW = $clog2(DATA_WIDTH + 1);

    gf_state_e             state_q, state_d;
    logic [PW-1:0]         d_q, d_d;
    logic [PW-1:0]         q_q, q_d;
    logic [DATA_WIDTH-1:0] v_q, v_d;
    logic [DATA_WIDTH-1:0] r_q, r_d;
    logic [DW-1:0]         deg_q, deg_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  accept;
    logic [DW-1:0]         div_deg;
    logic                  div_zero;

    logic [DATA_WIDTH:0]   t_raw;
    logic [TW-1:0]         t_idx;
    logic                  qb;
    logic [DATA_WIDTH-1:0] r_next;

`ifdef GF_DIV_ZERO_ERR_EN
    logic                  err_q, err_d;
`endif

    gf_deg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_deg (
        .poly_i (bus.divisor),
        .deg_o  (div_deg),
        .zero_o (div_zero)
    );

    assign accept = bus.in_valid && (state_q == IDLE);

    // One long-division step: bring down the next dividend bit, subtract the divisor if the lead term is set
    always_comb begin
        t_raw  = {r_q, d_q[PW-1]};
        t_idx  = TW'(deg_q);
        qb     = t_raw[t_idx];
        r_next = t_raw[DATA_WIDTH-1:0] ^ (qb ? v_q : '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a zero divisor skips the iteration phase entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid) state_d = div_zero ? DONE : RUN;
            RUN:  if (cnt_q == CW'(1)) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: load operands on accept, shift one bit per RUN cycle, hold otherwise
    always_comb begin
        d_d   = d_q;
        q_d   = q_q;
        v_d   = v_q;
        r_d   = r_q;
        deg_d = deg_q;
        cnt_d = cnt_q;
`ifdef GF_DIV_ZERO_ERR_EN
        err_d = err_q;
`endif
        if (accept) begin
            d_d   = bus.dividend;
            v_d   = bus.divisor;
            deg_d = div_deg;
            r_d   = '0;
            q_d   = '0;
            cnt_d = CW'(PW);
`ifdef GF_DIV_ZERO_ERR_EN
            err_d = div_zero;
`endif
        end else if (state_q == RUN) begin
            r_d   = r_next;
            q_d   = {q_q[PW-2:0], qb};
            d_d   = {d_q[PW-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Datapath registers; reset clears everything so an aborted operation leaves no residue
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q   <= '0;
            q_q   <= '0;
            v_q   <= '0;
            r_q   <= '0;
            deg_q <= '0;
            cnt_q <= '0;
`ifdef GF_DIV_ZERO_ERR_EN
            err_q <= 1'b0;
`endif
        end else begin
            d_q   <= d_d;
            q_q   <= q_d;
            v_q   <= v_d;
            r_q   <= r_d;
            deg_q <= deg_d;
            cnt_q <= cnt_d;
`ifdef GF_DIV_ZERO_ERR_EN
            err_q <= err_d;
`endif
        end
    end

    // Outputs decode from state; results are exposed only in DONE and stay frozen under backpressure
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.quotient  = (state_q == DONE) ? q_q : '0;
        bus.remainder = (state_q == DONE) ? r_q : '0;
`ifdef GF_DIV_ZERO_ERR_EN
        bus.div_err   = (state_q == DONE) && err_q;
`endif
    end

endmodule
